// File: rtl/paddle_bbox_tracker.sv
// paddle_bbox_tracker
//   Per-frame localizer for two mask colors. Walks a raster-order stream of
//   valid pixels, tracks column/row, and keeps per-color bounding box and
//   pixel count. On the last pixel of the frame it publishes found flag,
//   box, center and count for each color and pulses result_valid_o.
//
// Ports (color 1 = colorEncoding_i[1], color 2 = colorEncoding_i[0]):
//   clk_i            pixel clock
//   rst_n_i          asynchronous active-low reset
//   colorEncoding_i  mask bits of the current pixel
//   in_valid_i       pixel qualifier
//   sof_i            start of frame, marks pixel (0,0), only with in_valid_i
//   result_valid_o   one-cycle pulse, results updated on the preceding edge
//   found_c_o        count_c >= MIN_PIXELS
//   xmin/xmax/ymin/ymax_c_o  bounding box (0 when not found)
//   xcenter/ycenter_c_o      (min+max)>>1 (0 when not found)
//   count_c_o        saturating pixel count of color c in the frame
//
// state  | meaning
// IDLE   | waiting for an sof pixel, all other pixels ignored
// ACTIVE | accumulating the current frame
module paddle_bbox_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 10,
    parameter int CNT_WIDTH  = 19,
    parameter int MIN_PIXELS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [1:0]           colorEncoding_i,
    input  logic                 in_valid_i,
    input  logic                 sof_i,
    output logic                 result_valid_o,
    output logic                 found_1_o,
    output logic [X_WIDTH-1:0]   xmin_1_o,
    output logic [X_WIDTH-1:0]   xmax_1_o,
    output logic [Y_WIDTH-1:0]   ymin_1_o,
    output logic [Y_WIDTH-1:0]   ymax_1_o,
    output logic [X_WIDTH-1:0]   xcenter_1_o,
    output logic [Y_WIDTH-1:0]   ycenter_1_o,
    output logic [CNT_WIDTH-1:0] count_1_o,
    output logic                 found_2_o,
    output logic [X_WIDTH-1:0]   xmin_2_o,
    output logic [X_WIDTH-1:0]   xmax_2_o,
    output logic [Y_WIDTH-1:0]   ymin_2_o,
    output logic [Y_WIDTH-1:0]   ymax_2_o,
    output logic [X_WIDTH-1:0]   xcenter_2_o,
    output logic [Y_WIDTH-1:0]   ycenter_2_o,
    output logic [CNT_WIDTH-1:0] count_2_o
);

    localparam logic [X_WIDTH-1:0]   X_LAST  = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0]   Y_LAST  = Y_WIDTH'(V_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MIN = CNT_WIDTH'(MIN_PIXELS);

    typedef enum logic {S_IDLE, S_ACTIVE} state_e;

    state_e state_q, state_d;

    // Coordinates of the most recently accepted pixel.
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;
    logic [X_WIDTH-1:0] cur_x;
    logic [Y_WIDTH-1:0] cur_y;

    logic start, accept, last;
    logic [1:0] hit;

    // Index 0 is color 1, index 1 is color 2.
    logic [1:0][CNT_WIDTH-1:0] cnt_q,  cnt_d;
    logic [1:0][X_WIDTH-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
    logic [1:0][Y_WIDTH-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
    logic [1:0][X_WIDTH:0]     xsum;
    logic [1:0][Y_WIDTH:0]     ysum;

    logic [1:0]                res_found_q;
    logic [1:0][X_WIDTH-1:0]   res_xmin_q, res_xmax_q, res_xc_q;
    logic [1:0][Y_WIDTH-1:0]   res_ymin_q, res_ymax_q, res_yc_q;
    logic [1:0][CNT_WIDTH-1:0] res_cnt_q;
    logic                      result_valid_q;

    assign hit = {colorEncoding_i[0], colorEncoding_i[1]};

    always_comb begin
        start  = in_valid_i & sof_i;
        accept = in_valid_i & ((state_q == S_ACTIVE) | sof_i);

        if (start) begin
            cur_x = '0;
            cur_y = '0;
        end else if (x_q == X_LAST) begin
            cur_x = '0;
            cur_y = y_q + Y_WIDTH'(1);
        end else begin
            cur_x = x_q + X_WIDTH'(1);
            cur_y = y_q;
        end

        last = accept & (cur_x == X_LAST) & (cur_y == Y_LAST);

        state_d = state_q;
        if (last) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_ACTIVE;
        end
    end

    // Next accumulator values assuming the current pixel is accepted; an sof
    // pixel starts from the cleared values and still contributes itself.
    always_comb begin
        cnt_d  = cnt_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        xsum   = '0;
        ysum   = '0;
        for (int c = 0; c < 2; c++) begin
            if (start) begin
                cnt_d[c]  = '0;
                xmin_d[c] = '1;
                xmax_d[c] = '0;
                ymin_d[c] = '1;
                ymax_d[c] = '0;
            end
            if (hit[c]) begin
                if (cnt_d[c] != '1) begin
                    cnt_d[c] = cnt_d[c] + CNT_WIDTH'(1);
                end
                if (cur_x < xmin_d[c]) xmin_d[c] = cur_x;
                if (cur_x > xmax_d[c]) xmax_d[c] = cur_x;
                if (cur_y < ymin_d[c]) ymin_d[c] = cur_y;
                if (cur_y > ymax_d[c]) ymax_d[c] = cur_y;
            end
            xsum[c] = {1'b0, xmin_d[c]} + {1'b0, xmax_d[c]};
            ysum[c] = {1'b0, ymin_d[c]} + {1'b0, ymax_d[c]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q    <= cur_x;
                y_q    <= cur_y;
                cnt_q  <= cnt_d;
                xmin_q <= xmin_d;
                xmax_q <= xmax_d;
                ymin_q <= ymin_d;
                ymax_q <= ymax_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_valid_q <= 1'b0;
            res_found_q    <= '0;
            res_xmin_q     <= '0;
            res_xmax_q     <= '0;
            res_ymin_q     <= '0;
            res_ymax_q     <= '0;
            res_xc_q       <= '0;
            res_yc_q       <= '0;
            res_cnt_q      <= '0;
        end else begin
            result_valid_q <= last;
            if (last) begin
                for (int c = 0; c < 2; c++) begin
                    res_cnt_q[c] <= cnt_d[c];
                    if (cnt_d[c] >= CNT_MIN) begin
                        res_found_q[c] <= 1'b1;
                        res_xmin_q[c]  <= xmin_d[c];
                        res_xmax_q[c]  <= xmax_d[c];
                        res_ymin_q[c]  <= ymin_d[c];
                        res_ymax_q[c]  <= ymax_d[c];
                        res_xc_q[c]    <= xsum[c][X_WIDTH:1];
                        res_yc_q[c]    <= ysum[c][Y_WIDTH:1];
                    end else begin
                        res_found_q[c] <= 1'b0;
                        res_xmin_q[c]  <= '0;
                        res_xmax_q[c]  <= '0;
                        res_ymin_q[c]  <= '0;
                        res_ymax_q[c]  <= '0;
                        res_xc_q[c]    <= '0;
                        res_yc_q[c]    <= '0;
                    end
                end
            end
        end
    end

    assign result_valid_o = result_valid_q;

    assign found_1_o   = res_found_q[0];
    assign xmin_1_o    = res_xmin_q[0];
    assign xmax_1_o    = res_xmax_q[0];
    assign ymin_1_o    = res_ymin_q[0];
    assign ymax_1_o    = res_ymax_q[0];
    assign xcenter_1_o = res_xc_q[0];
    assign ycenter_1_o = res_yc_q[0];
    assign count_1_o   = res_cnt_q[0];

    assign found_2_o   = res_found_q[1];
    assign xmin_2_o    = res_xmin_q[1];
    assign xmax_2_o    = res_xmax_q[1];
    assign ymin_2_o    = res_ymin_q[1];
    assign ymax_2_o    = res_ymax_q[1];
    assign xcenter_2_o = res_xc_q[1];
    assign ycenter_2_o = res_yc_q[1];
    assign count_2_o   = res_cnt_q[1];

endmodule

// File: doc/paddle_bbox_tracker.md
# paddle_bbox_tracker

Per-frame localizer fed directly by the two-color mask stage. Consumes one 2-bit color encoding per valid pixel in raster order, tracks pixel column and row, and accumulates a bounding box and pixel count for each color. At end of frame it reports per-color found flag, box, center and count for the game logic.

## Interface
Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- X_WIDTH, 10: column coordinate width. Must satisfy H_ACTIVE ≤ 2^X_WIDTH.
- Y_WIDTH, 10: row coordinate width. Must satisfy V_ACTIVE ≤ 2^Y_WIDTH.
- CNT_WIDTH, 19: pixel counter width. Must hold H_ACTIVE*V_ACTIVE.
- MIN_PIXELS, 16: minimum count for a color to be reported found.

Ports (c ∈ {1,2}; color 1 = colorEncoding[1], color 2 = colorEncoding[0]):
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- colorEncoding, input, 2, mask bits of the current pixel.
- in_valid, input, 1, pixel qualifier.
- sof, input, 1, start of frame. Meaningful only with in_valid. Marks the pixel at (0,0).
- result_valid, output, 1, one-cycle pulse. Result outputs were updated on the preceding edge.
- found_c, output, 1, count_c ≥ MIN_PIXELS.
- xmin_c / xmax_c, output, X_WIDTH, column bounds.
- ymin_c / ymax_c, output, Y_WIDTH, row bounds.
- xcenter_c, output, X_WIDTH, (xmin_c+xmax_c)>>1.
- ycenter_c, output, Y_WIDTH, (ymin_c+ymax_c)>>1.
- count_c, output, CNT_WIDTH, pixels of color c in the frame (saturating).

## Operation
- FSM has two states.
  - IDLE (reset state): ignores all pixels until a pixel arrives with in_valid&sof.
  - ACTIVE: accumulates the frame.
- Accepted pixel means in_valid=1 while in ACTIVE, or the sof pixel that moves the FSM from IDLE to ACTIVE.
- Pixels with in_valid=0 have no effect on any state.
- An sof pixel (either state):
  - sets x=0, y=0;
  - clears accumulators: count=0, min=all-ones, max=0;
  - includes its own colorEncoding in the cleared accumulators.
- Each other accepted pixel:
  - x increments;
  - if x==H_ACTIVE-1, x wraps to 0 and y increments.
- Per color, on an accepted pixel with its bit set:
  - count increments, saturating at all-ones;
  - xmin=min(xmin,x), xmax=max(xmax,x);
  - ymin=min(ymin,y), ymax=max(ymax,y).
- Both bits set: both colors update independently.
- Last pixel is an accepted pixel at x=H_ACTIVE-1, y=V_ACTIVE-1.
- On the edge accepting the last pixel:
  - result registers load from the accumulators including that pixel;
  - FSM returns to IDLE.
- Result loading per color:
  - if count ≥ MIN_PIXELS: found=1, and bounds, centers and count load;
  - otherwise: found=0, and bounds and centers load 0 while count still loads the true count.
- sof in ACTIVE before the last pixel: the partial frame is discarded. No result_valid is produced, outputs are unchanged, and accumulation restarts at this pixel.
- Centers use an unsigned (WIDTH+1)-bit sum, shifted right by 1 (truncating).
- Result outputs hold their values between reports.

## Timing
- Reset (asynchronous, rst_n low): FSM=IDLE, x=y=0, accumulators cleared. All outputs are 0, including result_valid and found_c.
- Latency: result_valid=1 exactly in the cycle after the last-pixel edge, for one cycle. Results are stable from that cycle until the next report.
- Throughput: one pixel per clock. No backpressure, so in_valid may be high every cycle.
- sof arriving in the cycle right after the last pixel (while result_valid=1) is accepted normally and starts the next frame.
- Reset asserted mid-frame aborts the frame immediately. No result_valid is produced.
- colorEncoding and sof are ignored whenever in_valid=0.

## Test plan
Bench uses H_ACTIVE=8, V_ACTIVE=4, MIN_PIXELS=2.
1. Reset, then a full frame with color1 at (2,1), (5,1), (3,2) and color2 nowhere.
   - Required: result_valid pulses one cycle after pixel (7,3).
   - Color1: found=1, x 2..5, y 1..2, centers (3,1), count=3.
   - Color2: found=0, all fields 0, count=0.
2. Frame with color2 only at (7,3), the last pixel.
   - Required: count_2=1, found_2=0, bounds 0. Confirms the last pixel is included and the threshold is applied.
3. Frame with in_valid deasserted for random single cycles, and both mask bits set on pixels (0,0) and (7,3).
   - Required: both colors report found=1, x 0..7, y 0..3, center (3,1), count=2.
4. sof re-asserted at pixel 13 of a frame, followed by a full frame.
   - Required: no pulse for the aborted frame. The reported result reflects only the second frame.
5. Pixels streamed without a preceding sof, then rst_n pulsed low mid-frame.
   - Required: no result_valid, all outputs 0.
   - A subsequent clean frame reports correctly.
6. Two back-to-back frames, the second sof arriving in the result_valid cycle.
   - Required: both frames report, with pulses exactly 32 accepted pixels apart.
